// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle events into LED pulses of m cycles, each followed by a dark gap.
// Events arriving while a pulse is in progress are counted and replayed in order.
module led_pulse_stretcher #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned PEND_W = 4
) (
    input  logic              CLOCK,
    input  logic              RESETN,
    input  logic              TRIG,
    input  logic [CNT_W-1:0]  m,
    input  logic [CNT_W-1:0]  gap,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

    localparam logic [PEND_W-1:0] PendMax = '1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              trig_q;
    logic              armed_q;
    logic [PEND_W-1:0] pending_d;
    logic              overflow_d;
    logic              led_d, busy_d;
    logic              evt;
    logic              pend_inc, pend_dec;
    logic [CNT_W-1:0]  m_load, gap_load;

    // armed_q masks the first edge after reset, where trig_q is not yet a valid history.
    assign evt      = TRIG & ~trig_q & armed_q;
    assign m_load   = (m == '0) ? '0 : m - CNT_W'(1);
    assign gap_load = (gap == '0) ? '0 : gap - CNT_W'(1);

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            trig_q   <= 1'b0;
            armed_q  <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
            led      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            trig_q   <= TRIG;
            armed_q  <= 1'b1;
            pending  <= pending_d;
            overflow <= overflow_d;
            led      <= led_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_inc = 1'b0;
        pend_dec = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (evt) begin
                    state_d = StOn;
                    cnt_d   = m_load;
                end
            end
            StOn: begin
                pend_inc = evt;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = StGap;
                    cnt_d   = gap_load;
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    pend_inc = evt;
                end else if (pending != '0) begin
                    // Replay a queued event; a coincident new event takes its place in the queue.
                    state_d  = StOn;
                    cnt_d    = m_load;
                    pend_dec = 1'b1;
                    pend_inc = evt;
                end else if (evt) begin
                    state_d = StOn;
                    cnt_d   = m_load;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        pending_d  = pending;
        overflow_d = overflow;
        if (pend_inc && !pend_dec) begin
            if (pending == PendMax) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending + PEND_W'(1);
            end
        end else if (pend_dec && !pend_inc) begin
            pending_d = pending - PEND_W'(1);
        end
    end

    always_comb begin
        led_d  = (state_d == StOn);
        busy_d = (state_d != StIdle);
    end

endmodule
